// File: rtl/encode.sv
// Registered 4-to-2 priority encoder with a valid flag, a multi-hot flag
// and a parity bit over the raw input word. All four outputs are
// registered, so each result appears one clock after its input sample.
module encode #(
  // 1: the highest set bit of a wins; 0: the lowest set bit wins.
  parameter bit MSB_PRIORITY = 1'b1,
  // 0: parity is the XOR of a (even parity bit); 1: inverted XOR (odd).
  parameter bit ODD_PARITY   = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] a,
  output logic [1:0] out,
  output logic       parity,
  output logic       valid,
  output logic       multi
);

  logic [1:0] w_out;
  logic       w_parity;
  logic       w_valid;
  logic       w_multi;

  logic [1:0] r_out;
  logic       r_parity;
  logic       r_valid;
  logic       r_multi;

  // Priority selection: scan in the non-winning direction so that the
  // last set bit visited is the winner.
  always_comb begin
    // NOTE: the default assignment first means every path assigns w_out,
    // so no latch is inferred (it also gives out=0 for a=0).
    w_out = 2'b00;
    if (MSB_PRIORITY) begin
      for (int i = 0; i < 4; i++) begin
        if (a[i]) w_out = 2'(i);
      end
    end else begin
      for (int i = 3; i >= 0; i--) begin
        if (a[i]) w_out = 2'(i);
      end
    end
  end

  // Flags are independent of the priority direction. Clearing the lowest
  // set bit leaves something behind only when two or more bits were set.
  always_comb begin
    w_parity = (^a) ^ ODD_PARITY;
    w_valid  = |a;
    w_multi  = |(a & (a - 4'd1));
  end

  // Output register; reset clears everything, including parity in odd
  // mode, and discards whatever sample was in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out    <= 2'b00;
      r_parity <= 1'b0;
      r_valid  <= 1'b0;
      r_multi  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from
      // the pre-edge values, independent of statement order.
      r_out    <= w_out;
      r_parity <= w_parity;
      r_valid  <= w_valid;
      r_multi  <= w_multi;
    end
  end

  assign out    = r_out;
  assign parity = r_parity;
  assign valid  = r_valid;
  assign multi  = r_multi;

endmodule

// File: tb/tb_encode.sv
// Scoreboard bench for encode: two instances cover both priority
// directions and both parity modes. Stimulus pushes hand-computed
// expectations; a monitor pops and compares one cycle later.
module tb_encode;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] a   = 4'b0000;

  logic [1:0] out_h, out_l;
  logic       par_h, par_l;
  logic       valid_h, valid_l;
  logic       multi_h, multi_l;

  int n_checks = 0;
  int n_errors = 0;

  // Hand-computed reference tables, indexed by the value of a.
  logic [1:0] k_out_msb [16] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2,
                                 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3, 2'd3};
  logic [1:0] k_out_lsb [16] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0,
                                 2'd3, 2'd0, 2'd1, 2'd0, 2'd2, 2'd0, 2'd1, 2'd0};
  logic [15:0] k_par_even = 16'b0110_1001_1001_0110;
  logic [15:0] k_multi    = 16'b1111_1110_1110_1000;

  typedef struct packed {
    logic [3:0] a;
    logic [1:0] out_h;
    logic       par_h;
    logic [1:0] out_l;
    logic       par_l;
    logic       valid;
    logic       multi;
  } exp_t;

  exp_t q[$];

  // MSB priority, even parity.
  encode #(.MSB_PRIORITY(1'b1), .ODD_PARITY(1'b0)) u_dut_h (
    .clk(clk), .rst(rst), .a(a),
    .out(out_h), .parity(par_h), .valid(valid_h), .multi(multi_h)
  );

  // LSB priority, odd parity.
  encode #(.MSB_PRIORITY(1'b0), .ODD_PARITY(1'b1)) u_dut_l (
    .clk(clk), .rst(rst), .a(a),
    .out(out_l), .parity(par_l), .valid(valid_l), .multi(multi_l)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] actual,
                       input logic [7:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic push_exp(input logic [3:0] v);
    exp_t e;
    e.a     = v;
    e.out_h = k_out_msb[v];
    e.par_h = k_par_even[v];
    e.out_l = k_out_lsb[v];
    e.par_l = ~k_par_even[v];
    e.valid = (v != 4'b0000);
    e.multi = k_multi[v];
    q.push_back(e);
  endtask

  task automatic apply(input logic [3:0] v);
    @(negedge clk);
    a = v;
    push_exp(v);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, ".out_h"},   {6'd0, out_h},   8'd0);
    check({tag, ".par_h"},   {7'd0, par_h},   8'd0);
    check({tag, ".valid_h"}, {7'd0, valid_h}, 8'd0);
    check({tag, ".multi_h"}, {7'd0, multi_h}, 8'd0);
    check({tag, ".out_l"},   {6'd0, out_l},   8'd0);
    check({tag, ".par_l"},   {7'd0, par_l},   8'd0);
    check({tag, ".valid_l"}, {7'd0, valid_l}, 8'd0);
    check({tag, ".multi_l"}, {7'd0, multi_l}, 8'd0);
  endtask

  // Monitor: every sampled input yields a result just after the next edge.
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("a=%b out_h", e.a),   {6'd0, out_h},   {6'd0, e.out_h});
      check($sformatf("a=%b par_h", e.a),   {7'd0, par_h},   {7'd0, e.par_h});
      check($sformatf("a=%b valid_h", e.a), {7'd0, valid_h}, {7'd0, e.valid});
      check($sformatf("a=%b multi_h", e.a), {7'd0, multi_h}, {7'd0, e.multi});
      check($sformatf("a=%b out_l", e.a),   {6'd0, out_l},   {6'd0, e.out_l});
      check($sformatf("a=%b par_l", e.a),   {7'd0, par_l},   {7'd0, e.par_l});
      check($sformatf("a=%b valid_l", e.a), {7'd0, valid_l}, {7'd0, e.valid});
      check($sformatf("a=%b multi_l", e.a), {7'd0, multi_l}, {7'd0, e.multi});
    end
  end

  initial begin
    // Asynchronous reset before any clock edge, with all inputs set.
    a = 4'b1111;
    #1 rst = 1'b1;
    #1 check_cleared("reset_async");
    repeat (2) @(posedge clk);
    #2 check_cleared("reset_hold");

    // Release together with the first sample.
    @(negedge clk);
    rst = 1'b0;
    a   = 4'b0100;
    push_exp(4'b0100);

    // One-hot, zero and multi-hot directed vectors.
    apply(4'b0001);
    apply(4'b0010);
    apply(4'b1000);
    apply(4'b0000);
    apply(4'b0110);
    apply(4'b1111);

    // Input changes between edges must not reach the outputs early.
    apply(4'b0001);
    @(posedge clk);
    #3;
    a = 4'b1000;
    push_exp(4'b1000);
    #1;
    check("latency.out_h", {6'd0, out_h},   8'd0);
    check("latency.out_l", {6'd0, out_l},   8'd0);
    check("latency.valid", {7'd0, valid_h}, 8'd1);
    @(posedge clk);

    // Reset mid-operation after 1000 was sampled clears immediately.
    #3;
    check("pre_reset.out_h", {6'd0, out_h}, 8'd3);
    rst = 1'b1;
    #1 check_cleared("reset_mid");
    @(posedge clk);
    #2 check_cleared("reset_mid_hold");
    @(negedge clk);
    rst = 1'b0;
    a   = 4'b1000;
    push_exp(4'b1000);

    // Full sweep in both parameter modes (two instances).
    for (int v = 0; v < 16; v++) apply(4'(v));

    // Drain with a bounded wait.
    for (int i = 0; i < 5 && q.size() > 0; i++) @(posedge clk);
    #2;
    check("drain.queue_empty", 8'(q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/encode.md
Name: encode

Overview:
- Registered 4-to-2 priority encoder with a parity bit over the raw input word.
- Converts a 4-bit request/one-hot vector `a` into a 2-bit index `out`.
- Flags whether any input bit was set (`valid`) and whether more than one was set (`multi`).
- Sits between a 4-line request/status source and downstream index-consuming logic; one clock of latency, all outputs registered.

Parameters:
- MSB_PRIORITY, 1, 1 = highest set bit of `a` wins; 0 = lowest set bit wins.
- ODD_PARITY, 0, 0 = `parity` is XOR of `a[3:0]` (even parity bit); 1 = inverted XOR (odd parity bit).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- a  input  4  input request/one-hot vector, sampled every rising clk edge.
- out  output  2  encoded index of the winning set bit of `a`.
- parity  output  1  parity of `a` per ODD_PARITY.
- valid  output  1  1 when at least one bit of `a` was set.
- multi  output  1  1 when two or more bits of `a` were set.

Behaviour:
- Reset: `rst`=1 immediately (asynchronously) forces out=2'b00, parity=0, valid=0, multi=0, regardless of clk.
  - Release of rst takes effect at the next rising clk edge.
  - Asserting rst mid-operation discards the sampled value; no pending result survives.
- Latency: on every rising clk edge with rst=0, all four outputs load values computed combinationally from the current `a`.
  - Results are visible one cycle after `a` is applied.
  - No handshake; a new sample is taken every cycle.
  - Outputs hold between edges.
- Encoding with MSB_PRIORITY=1:
  - a[3]=1 -> 3.
  - else a[2]=1 -> 2.
  - else a[1]=1 -> 1.
  - else a[0]=1 -> 0.
- Encoding with MSB_PRIORITY=0: the search order is reversed (a[0] first).
- a=4'b0000:
  - out=2'b00, valid=0, multi=0.
  - parity = 0 (even mode) or 1 (odd mode).
- parity is computed over all four bits of `a`, independent of priority selection.
  - Even mode: 1 when `a` has an odd number of ones.
- multi=1 iff popcount(a) >= 2; `out` still reports the priority winner in that case.
- Input X/Z handling is not defined; `a` must be driven to known values.
- Fully synchronous datapath apart from the async reset; no other state, no internal counters.

Test Plan:
- Reset: assert rst with a=4'b1111 -> out=00, parity=0, valid=0, multi=0 immediately, without waiting for a clk edge; outputs hold while rst=1.
- One-hot: a=4'b0100, one clk edge -> out=2'b10, parity=1, valid=1, multi=0; repeat for 0001/0010/1000 -> out=00/01/11, parity=1, valid=1.
- Zero input: a=4'b0000 -> out=00, parity=0, valid=0, multi=0 (odd mode: parity=1).
- Multi-hot:
  - a=4'b0110 -> out=10, parity=0, valid=1, multi=1.
  - a=4'b1111 -> out=11, parity=0, multi=1.
  - With MSB_PRIORITY=0, a=4'b0110 -> out=01.
- Latency and reset mid-operation:
  - Change `a` between edges -> outputs change only at the next rising edge.
  - Assert rst between edges after a=4'b1000 was sampled -> outputs clear immediately; after release and one edge with a=4'b1000 -> out=11, valid=1.
- Exhaustive sweep: all 16 values of `a` in both parameter modes -> compare out/parity/valid/multi against the reference model, with one-cycle delay.
